// File: rtl/pwm_2_pkg.sv
// pwm_2_pkg: shared defaults and helpers for the push-button PWM generator.
//   Default period, duty step, initial duty, clamps and debounce length, all in
//   clk cycles, plus the width helper used to size counters and registers.
package pwm_2_pkg;

  localparam int unsigned PERIOD_CYCLES_DEF   = 100;
  localparam int unsigned STEP_CYCLES_DEF     = 5;
  localparam int unsigned DUTY_INIT_DEF       = 50;
  localparam int unsigned DUTY_MIN_DEF        = 5;
  localparam int unsigned DUTY_MAX_DEF        = 95;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pwm_2_pb_debounce.sv
// pb_debounce: conditions one raw active-low push-button.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   pb_n        : raw button pin, active-low, asynchronous to clk
//   press_pulse : one-cycle pulse per accepted press (debounced 1->0 edge)
module pb_debounce
  import pwm_2_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic press_pulse
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so short glitches never get through.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Only the press edge (released -> pressed) is reported.
    pulse_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= pb_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/pwm_2.sv
// pwm_2: single-channel PWM whose duty is stepped by two active-low buttons.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   pb_inc  : raw increment button, active-low
//   pb_dec  : raw decrement button, active-low
//   pwm_out : registered PWM output, high for duty cycles of every period
module pwm_2
  import pwm_2_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES   = PERIOD_CYCLES_DEF,
  parameter int unsigned STEP_CYCLES     = STEP_CYCLES_DEF,
  parameter int unsigned DUTY_INIT       = DUTY_INIT_DEF,
  parameter int unsigned DUTY_MIN        = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX        = DUTY_MAX_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_inc,
  input  logic pb_dec,
  output logic pwm_out
);

  localparam int unsigned CW = cnt_width(PERIOD_CYCLES);
  // One guard bit so the step arithmetic can overflow/underflow visibly.
  localparam int unsigned AW = CW + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] INIT_C    = CW'(DUTY_INIT);
  localparam logic [AW-1:0] STEP_A    = AW'(STEP_CYCLES);
  localparam logic [AW-1:0] MIN_A     = AW'(DUTY_MIN);
  localparam logic [AW-1:0] MAX_A     = AW'(DUTY_MAX);

  if (!(DUTY_MIN <= DUTY_INIT && DUTY_INIT <= DUTY_MAX &&
        DUTY_MAX <= PERIOD_CYCLES && STEP_CYCLES > 0)) begin : g_param_check
    $error("pwm_2: illegal duty/step parameters");
  end

  logic inc_pulse, dec_pulse;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk         (clk),
    .rst         (rst),
    .pb_n        (pb_inc),
    .press_pulse (inc_pulse)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk         (clk),
    .rst         (rst),
    .pb_n        (pb_dec),
    .press_pulse (dec_pulse)
  );

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic [AW-1:0] sum_a, diff_a;

  always_comb begin
    sum_a    = {1'b0, shadow_q} + STEP_A;
    diff_a   = {1'b0, shadow_q} - STEP_A;
    shadow_d = shadow_q;
    // Simultaneous presses cancel out.
    if (inc_pulse && !dec_pulse) begin
      shadow_d = (sum_a > MAX_A) ? CW'(MAX_A) : CW'(sum_a);
    end else if (dec_pulse && !inc_pulse) begin
      // Guard bit set means the subtraction went below zero.
      shadow_d = (diff_a[AW-1] || diff_a < MIN_A) ? CW'(MIN_A) : CW'(diff_a);
    end

    // Active duty only changes at the period boundary, so every pulse is whole.
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      duty_d = shadow_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      duty_d = duty_q;
    end

    pwm_d = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      shadow_q <= INIT_C;
      duty_q   <= INIT_C;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_2.sv
// tb_pwm_2: table-driven check of pwm_2 high time and period per press action.
module tb_pwm_2;

  localparam int PERIOD = 100;
  localparam int STEP   = 5;
  localparam int DMIN   = 5;
  localparam int DMAX   = 95;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pb_inc = 1'b1;
  logic pb_dec = 1'b1;
  logic pwm_out;

  always #10 clk = ~clk;   // 50 MHz

  pwm_2 dut (
    .clk     (clk),
    .rst     (rst),
    .pb_inc  (pb_inc),
    .pb_dec  (pb_dec),
    .pwm_out (pwm_out)
  );

  typedef enum int {OP_NONE, OP_INC, OP_DEC, OP_BOTH, OP_GLITCH, OP_HOLD} op_e;
  typedef struct {
    op_e op;
    int  exp_high;
  } vec_t;

  vec_t vecs[64];
  int   n_vecs = 0;
  int   exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   model_duty = 50;

  function automatic int sat_inc(input int d);
    return (d + STEP > DMAX) ? DMAX : d + STEP;
  endfunction
  function automatic int sat_dec(input int d);
    return (d - STEP < DMIN) ? DMIN : d - STEP;
  endfunction

  task automatic add_vec(input op_e op);
    case (op)
      OP_INC, OP_HOLD: model_duty = sat_inc(model_duty);
      OP_DEC:          model_duty = sat_dec(model_duty);
      default:         model_duty = model_duty;
    endcase
    vecs[n_vecs].op       = op;
    vecs[n_vecs].exp_high = model_duty;
    n_vecs++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Drive one button action on a falling edge, then leave a long quiet gap.
  task automatic press(input op_e op);
    @(negedge clk);
    case (op)
      OP_INC:    begin pb_inc = 1'b0; repeat (25) @(negedge clk); pb_inc = 1'b1; end
      OP_DEC:    begin pb_dec = 1'b0; repeat (25) @(negedge clk); pb_dec = 1'b1; end
      OP_BOTH:   begin pb_inc = 1'b0; pb_dec = 1'b0; repeat (25) @(negedge clk);
                       pb_inc = 1'b1; pb_dec = 1'b1; end
      OP_GLITCH: begin pb_inc = 1'b0; repeat (10) @(negedge clk); pb_inc = 1'b1; end
      OP_HOLD:   begin pb_inc = 1'b0; repeat (400) @(negedge clk); pb_inc = 1'b1; end
      default:   ;
    endcase
    repeat (250) @(negedge clk);
  endtask

  // Sync to a rising edge of pwm_out, then count one high and one low phase.
  task automatic measure(output int hi, output int lo, output bit ok);
    bit prev;
    int t;
    ok = 1'b0; hi = 0; lo = 0;
    @(negedge clk);
    prev = pwm_out;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!prev && pwm_out) break;
      prev = pwm_out;
    end
    if (t == 400) return;
    hi = 1;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (pwm_out) hi++; else break;
    end
    if (t == 400) return;
    lo = 1;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!pwm_out) lo++; else break;
    end
    if (t == 400) return;
    ok = 1'b1;
  endtask

  task automatic measure_and_check(input string tag);
    int hi, lo, exp;
    bit ok;
    measure(hi, lo, ok);
    exp = exp_q.pop_front();
    if (!ok) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_high"}, hi, exp);
      check({tag, "_period"}, hi + lo, PERIOD);
    end
  endtask

  initial begin
    // Table: idle, inc x3, dec x14 (to the floor), inc x20 (to the ceiling),
    // then hold / glitch / simultaneous presses that must change at most one step.
    add_vec(OP_NONE);
    for (int i = 0; i < 3;  i++) add_vec(OP_INC);
    for (int i = 0; i < 14; i++) add_vec(OP_DEC);
    for (int i = 0; i < 20; i++) add_vec(OP_INC);
    vecs[n_vecs].op = OP_DEC; model_duty = sat_dec(model_duty);
    vecs[n_vecs].exp_high = model_duty; n_vecs++;
    add_vec(OP_HOLD);
    add_vec(OP_GLITCH);
    add_vec(OP_BOTH);

    // Reset state: output held low while rst is asserted.
    repeat (3) @(negedge clk);
    check("reset_pwm_low", int'(pwm_out), 0);
    repeat (5) @(negedge clk);
    check("reset_pwm_still_low", int'(pwm_out), 0);
    rst = 1'b1;

    for (int v = 0; v < n_vecs; v++) begin
      string tag;
      tag = $sformatf("v%0d_op%0d", v, int'(vecs[v].op));
      press(vecs[v].op);
      exp_q.push_back(vecs[v].exp_high);
      measure_and_check(tag);
    end

    // Mid-period asynchronous reset: output must drop without a clock edge.
    begin
      bit prev;
      int t;
      @(negedge clk);
      prev = pwm_out;
      for (t = 0; t < 400; t++) begin
        @(negedge clk);
        if (!prev && pwm_out) break;
        prev = pwm_out;
      end
      check("pre_reset_found_rise", int'(t < 400), 1);
      repeat (10) @(negedge clk);
      check("pre_reset_high", int'(pwm_out), 1);
      #2 rst = 1'b0;
      #1 check("async_reset_clears", int'(pwm_out), 0);
      #97 rst = 1'b1;
      model_duty = 50;
      exp_q.push_back(model_duty);
      measure_and_check("after_reset");
      press(OP_INC);
      model_duty = sat_inc(model_duty);
      exp_q.push_back(model_duty);
      measure_and_check("after_reset_inc");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_2.md
Name: pwm_2

Overview:
Single-channel PWM generator with duty cycle adjustable by two push-buttons. Both buttons are active-low. Each debounced press of pb_inc raises the duty cycle by one step; each debounced press of pb_dec lowers it by one step. Duty is clamped between a minimum and maximum. The block sits at the board edge: raw button pins in, pwm_out drives an LED, motor driver or similar load.

Parameters:
- PERIOD_CYCLES, 100: PWM period in clk cycles (2 us at 50 MHz).
- STEP_CYCLES, 5: duty change per press, in clk cycles (5 % of period).
- DUTY_INIT, 50: duty after reset, in clk cycles (50 %).
- DUTY_MIN, 5: lower clamp, in clk cycles (5 %).
- DUTY_MAX, 95: upper clamp, in clk cycles (95 %).
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a new button level.

Ports:
- clk  input  1  system clock, 50 MHz; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pb_inc  input  1  raw increment button, active-low (0 = pressed), asynchronous to clk.
- pb_dec  input  1  raw decrement button, active-low (0 = pressed), asynchronous to clk.
- pwm_out  output  1  PWM output, active-high.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (rst = 0 resets immediately, independent of clk).
- Reset values:
  - period counter = 0
  - duty register and shadow duty = DUTY_INIT
  - synchronizer and debounced button states = 1 (released)
  - debounce counters = 0
  - pwm_out = 0
- Input path, per button:
  - 2-FF synchronizer.
  - Debounce: counter runs while the synchronized level differs from the debounced state and clears when they match. On reaching DEBOUNCE_CYCLES, the debounced state takes the new level.
  - A debounced 1->0 transition produces a single-cycle press pulse. Release produces nothing. Holding the button yields exactly one step.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Duty update (shadow register):
  - inc pulse only: shadow = min(shadow + STEP_CYCLES, DUTY_MAX).
  - dec pulse only: shadow = max(shadow - STEP_CYCLES, DUTY_MIN).
  - Both pulses in the same cycle: no change.
  - Saturating, never wraps. Arithmetic width is clog2(PERIOD_CYCLES+1) bits plus one guard bit for the compare.
- Period counter: counts 0 .. PERIOD_CYCLES-1, then wraps to 0. At the wrap (counter == PERIOD_CYCLES-1), duty register <= shadow. New duty therefore takes effect only at a period boundary, so there are no partial or glitched pulses.
- Output: pwm_out registered; next value = (counter < duty). High time = duty cycles, low time = PERIOD_CYCLES - duty cycles, per period.
- Latency from raw press to shadow update: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. Visible on pwm_out from the next period start, plus 1 register cycle.
- Reset mid-operation: everything returns to reset values. The first period after release of rst starts at counter 0 with 50 % duty.
- Parameter legality (elaboration check): DUTY_MIN <= DUTY_INIT <= DUTY_MAX <= PERIOD_CYCLES, and STEP_CYCLES > 0.

Decomposition:
- Package pwm_2_pkg: default constants for period, step, init, min, max, debounce length; counter-width function.
- One natural sub-module, pb_debounce:
  - Contains the synchronizer, debounce counter and falling-edge pulse.
  - Instantiated twice, once for pb_inc and once for pb_dec.
  - Ports: clk, rst, pb_n in, press_pulse out.
- Top level contains the duty shadow/active registers, the period counter and the comparator.

Test Plan:
- Reset, no presses, 50 us: pwm_out period 2000 ns; high 1000 ns, low 1000 ns.
- 3 inc presses (500 ns low, 5000 ns gap each): high time 55, 60, 65 cycles. Final high 1300 ns, low 700 ns.
- Then 5 dec presses: high time 60, 55, 50, 45, 40 cycles.
- 5 further dec presses: 35, 30, 25, 20, 15. Continued dec presses reach 5 and stay at 5 cycles (100 ns high), never 0.
- 20 inc presses from 5: saturates at 95 cycles (1900 ns high, 100 ns low) and stays there; pwm_out never constant-high.
- Asserting rst (low) for 100 ns mid-period, then releasing:
  - pwm_out = 0 immediately.
  - Next period is 50 % duty.
  - Additionally check that a 200 ns (10-cycle) press glitch and a simultaneous inc+dec press both leave duty unchanged.
